carry_save_seq_4: RTL and testbench

Sequencer for the 4-bit carry-save adder with carry-lookahead final stage (`carry_save_adder_cla_4`). It collects a stream of 4-bit operands over a valid/ready input handshake and groups them into triples, zero-filling short groups. Each triple drives one internal `carry_save_adder_cla_4` instance, and the registered result is presented over a valid/ready output handshake. It sits between an operand source (register file or test driver) and any consumer of three-operand sums.

---
 rtl/carry_save_seq_4.sv | 152 +++++++++++++++
 tb/tb_carry_save_seq_4.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/carry_save_seq_4.sv
// Three-operand 4-bit adder (carry-save stage + carry-lookahead final stage) and its operand sequencer.
// Latency: result visible one cycle after the last operand is accepted (one S_ADD cycle).
// Backpressure: in_ready low while adding or holding a result; result held until out_ready.

module carry_save_adder_cla_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  output logic [4:0] sum,
  output logic       cout
);

  logic [3:0] s_vec;
  logic [3:0] c_vec;
  logic [4:0] x;
  logic [4:0] y;
  logic [4:0] p;
  logic [4:0] g;
  logic [5:0] cy;

  // Reduce three operands to sum/carry vectors, then resolve them with generate/propagate carries
  always_comb begin
    s_vec = a ^ b ^ c;
    c_vec = (a & b) | (a & c) | (b & c);
    x     = {1'b0, s_vec};
    y     = {c_vec, 1'b0};
    p     = x ^ y;
    g     = x & y;
    cy    = 6'd0;
    for (int i = 0; i < 5; i++) begin
      cy[i+1] = g[i] | (p[i] & cy[i]);
    end
    sum  = p ^ cy[4:0];
    cout = cy[5];
  end

endmodule

module carry_save_seq_4 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_sum,
  output logic             out_cout,
  output logic [1:0]       out_ops,
  output logic [CNT_W-1:0] grp_count
);

  typedef enum logic [2:0] {
    S_OP0,
    S_OP1,
    S_OP2,
    S_ADD,
    S_OUT
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;
  logic [1:0] ops;
  logic [4:0] add_sum;
  logic       add_cout;
  logic       accept;
  logic       take;

  assign accept = in_valid && in_ready;
  assign take   = out_valid && out_ready;

  carry_save_adder_cla_4 u_add (
    .a    (a),
    .b    (b),
    .c    (c),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_OP0;
    else     state <= state_nxt;
  end

  // Next state and Moore handshake outputs; in_last only closes a group early in OP0/OP1
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_OP0: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? S_ADD : S_OP1;
      end
      S_OP1: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? S_ADD : S_OP2;
      end
      S_OP2: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_ADD;
      end
      S_ADD: state_nxt = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_OP0;
      end
      default: state_nxt = S_OP0;
    endcase
  end

  // Operand capture, result registration and delivered-group counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a         <= 4'd0;
      b         <= 4'd0;
      c         <= 4'd0;
      ops       <= 2'd0;
      out_sum   <= 5'd0;
      out_cout  <= 1'b0;
      out_ops   <= 2'd0;
      grp_count <= '0;
    end else begin
      case (state)
        S_OP0: if (accept) begin a <= in_data; ops <= 2'd1; end
        S_OP1: if (accept) begin b <= in_data; ops <= 2'd2; end
        S_OP2: if (accept) begin c <= in_data; ops <= 2'd3; end
        S_ADD: begin
          out_sum  <= add_sum;
          out_cout <= add_cout;
          out_ops  <= ops;
        end
        S_OUT: if (take) begin
          // Clearing here keeps unloaded slots of the next short group at zero
          a         <= 4'd0;
          b         <= 4'd0;
          c         <= 4'd0;
          grp_count <= grp_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carry_save_seq_4.sv
module tb_carry_save_seq_4;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_data = 4'd0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [4:0]       out_sum;
  logic             out_cout;
  logic [1:0]       out_ops;
  logic [CNT_W-1:0] grp_count;

  int n_pass  = 0;
  int n_chk   = 0;
  int grp_exp = 0;

  carry_save_seq_4 #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ops   (out_ops),
    .grp_count (grp_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},  int'(in_ready),  1);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_sum"},   int'(out_sum),   0);
    check({tag, "_out_cout"},  int'(out_cout),  0);
    check({tag, "_out_ops"},   int'(out_ops),   0);
    check({tag, "_grp_count"}, int'(grp_count), 0);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic pulse_reset(input string tag);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1 check_reset_state(tag);
    grp_exp = 0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Offer one operand after 'gap' idle cycles; returns once it is accepted (or times out)
  task automatic push(input logic [3:0] d, input logic l, input int gap, output bit ok);
    bit done;
    in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    ok   = 1'b0;
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok   = 1'b1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 4'($urandom);
  endtask

  // Send a group of n operands, check the result and its timing, then hand it off after 'hold' stall cycles
  task automatic run_group(input int n, input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input int gap, input int hold);
    logic [3:0] d[3];
    int         exp;
    bit         ok;
    logic       l;
    d[0] = d0; d[1] = d1; d[2] = d2;
    exp = 0;
    for (int i = 0; i < n; i++) begin
      exp += int'(d[i]);
      if (i == n - 1 && n < 3) l = 1'b1;
      else if (i == 2)         l = 1'($urandom);
      else                     l = 1'b0;
      push(d[i], l, gap, ok);
      check("accept", int'(ok), 1);
    end
    @(negedge clk);
    check("add_cycle_out_valid", int'(out_valid), 0);
    check("add_cycle_in_ready",  int'(in_ready),  0);
    @(negedge clk);
    check("latency_out_valid", int'(out_valid), 1);
    check("result",  int'({out_cout, out_sum}), exp);
    check("out_ops", int'(out_ops), n);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = 4'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_in_ready",  int'(in_ready),  0);
      check("hold_result",    int'({out_cout, out_sum}), exp);
      check("hold_grp_count", int'(grp_count), grp_exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    grp_exp   = (grp_exp + 1) % (1 << CNT_W);
    check("grp_count",        int'(grp_count), grp_exp);
    check("after_out_valid",  int'(out_valid), 0);
    check("after_in_ready",   int'(in_ready),  1);
  endtask

  initial begin
    bit ok;
    #12;
    check_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_group(3, 4'd1,  4'd1,  4'd1,  0, 0);
    run_group(3, 4'd15, 4'd15, 4'd15, 0, 4);
    run_group(2, 4'd5,  4'd7,  4'd0,  0, 0);
    run_group(1, 4'd9,  4'd0,  4'd0,  0, 0);
    run_group(3, 4'd3,  4'd4,  4'd8,  2, 0);

    // Reset with a partial group in flight
    push(4'd11, 1'b0, 0, ok);
    push(4'd13, 1'b0, 0, ok);
    pulse_reset("rst_mid_group");
    run_group(3, 4'd2, 4'd2, 4'd2, 0, 0);

    // Reset while a result is waiting for the consumer
    push(4'd6, 1'b1, 0, ok);
    @(negedge clk);
    @(negedge clk);
    check("valid_before_rst", int'(out_valid), 1);
    pulse_reset("rst_out_valid");

    // Counter wrap: 1, 2, 3, 0, 1
    for (int g = 0; g < 5; g++)
      run_group(3, 4'($urandom), 4'($urandom), 4'($urandom), 0, 0);

    for (int g = 0; g < 25; g++)
      run_group($urandom_range(1, 3), 4'($urandom), 4'($urandom), 4'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
